// File: rtl/shift_normalizer.sv
// Multi-cycle left-shift normalizer: shifts an operand left one bit per cycle
// until it is normalized (unsigned: MSB set; signed: top two bits differ) and
// reports the number of shifts applied.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   start           request, accepted only in IDLE or DONE
//   mode            0 = unsigned, 1 = signed normalize (captured with start)
//   in              operand (captured with start)
//   busy            high while shifting
//   done            one-cycle pulse, out/count/zero valid
//   out, count      normalized value and shift count, held until next result
//   zero            operand was all zeros
module shift_normalizer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] r, r_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             mode_q, mode_nxt;
   logic [WIDTH-1:0] out_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic             zero_nxt;
   logic             normalized;

   // Termination test on the working register for the captured mode
   assign normalized = mode_q ? (r[WIDTH-1] != r[WIDTH-2]) : r[WIDTH-1];

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         r      <= '0;
         cnt    <= '0;
         mode_q <= 1'b0;
         out    <= '0;
         count  <= '0;
         zero   <= 1'b0;
      end else begin
         state  <= state_nxt;
         r      <= r_nxt;
         cnt    <= cnt_nxt;
         mode_q <= mode_nxt;
         out    <= out_nxt;
         count  <= count_nxt;
         zero   <= zero_nxt;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt = state;
      r_nxt     = r;
      cnt_nxt   = cnt;
      mode_nxt  = mode_q;
      out_nxt   = out;
      count_nxt = count;
      zero_nxt  = zero;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = SHIFT;
               r_nxt     = in;
               mode_nxt  = mode;
               cnt_nxt   = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (r == '0) begin
               state_nxt = DONE;
               out_nxt   = '0;
               count_nxt = '0;
               zero_nxt  = 1'b1;
            end else if (normalized) begin
               state_nxt = DONE;
               out_nxt   = r;
               count_nxt = cnt;
               zero_nxt  = 1'b0;
            end else begin
               r_nxt   = {r[WIDTH-2:0], 1'b0};
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Status flags are direct decodes of the state register
   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer: the driver pushes hand-computed
// results per accepted start; the monitor pops and compares on each done.
module tb_shift_normalizer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        mode;
   logic [15:0] in;
   logic        busy, done, zero;
   logic [15:0] out;
   logic [4:0]  count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] out;
      logic [4:0]  cnt;
      logic        zero;
      int          lat;
      time         t0;
   } exp_t;

   exp_t q[$];

   shift_normalizer #(.WIDTH(16), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .in(in),
      .busy(busy), .done(done), .out(out), .count(count), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare every done pulse against the head of the scoreboard
   int busy_cnt = 0;
   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out",     32'(out),   32'(e.out));
            chk("count",   32'(count), 32'(e.cnt));
            chk("zero",    32'(zero),  32'(e.zero));
            chk("latency", 32'(int'(($time - e.t0 - 5) / 10)), 32'(e.lat));
            chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
         end
         busy_cnt = 0;
      end else if (busy) begin
         busy_cnt++;
      end else begin
         busy_cnt = 0;
      end
   end

   // Issue a start at the current negedge; accepted on the following posedge
   task automatic run(input logic [15:0] v, input logic m, input logic [15:0] eo,
                      input int k, input logic ez, input bit push);
      exp_t e;
      in    = v;
      mode  = m;
      start = 1'b1;
      @(posedge clk);
      if (push) begin
         e.out  = eo;
         e.cnt  = 5'(k);
         e.zero = ez;
         e.lat  = k + 1;
         e.t0   = $time;
         q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait for the done pulse with a cycle budget; returns at that negedge
   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"},  32'(busy),  32'd0);
      chk({tag, "_done"},  32'(done),  32'd0);
      chk({tag, "_out"},   32'(out),   32'd0);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_zero"},  32'(zero),  32'd0);
   endtask

   initial begin
      bit stray_done;
      reset = 1'b1;
      start = 1'b1;
      mode  = 1'b0;
      in    = 16'h1234;
      repeat (3) @(negedge clk);
      check_idle("reset");
      start = 1'b0;
      reset = 1'b0;
      @(negedge clk);

      // Unsigned, signed and zero operands
      run(16'h0001, 1'b0, 16'h8000, 15, 1'b0, 1'b1); wait_done();
      @(negedge clk);
      run(16'h8000, 1'b0, 16'h8000,  0, 1'b0, 1'b1); wait_done();
      @(negedge clk);
      run(16'h0030, 1'b1, 16'h6000,  9, 1'b0, 1'b1); wait_done();
      @(negedge clk);
      run(16'hFFFF, 1'b1, 16'h8000, 15, 1'b0, 1'b1); wait_done();
      @(negedge clk);
      run(16'h0000, 1'b0, 16'h0000,  0, 1'b1, 1'b1); wait_done();
      @(negedge clk);
      run(16'h0000, 1'b1, 16'h0000,  0, 1'b1, 1'b1); wait_done();
      @(negedge clk);
      run(16'h0003, 1'b1, 16'h6000, 13, 1'b0, 1'b1); wait_done();
      @(negedge clk);
      run(16'hFF00, 1'b1, 16'h8000,  7, 1'b0, 1'b1); wait_done();
      @(negedge clk);

      // Start while busy is ignored; inputs changed mid-operation have no effect
      run(16'h0001, 1'b0, 16'h8000, 15, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      in    = 16'h1234;
      mode  = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      // Back-to-back: start held during the DONE cycle
      run(16'h4000, 1'b1, 16'h4000,  0, 1'b0, 1'b1); wait_done();
      @(negedge clk);

      // Reset mid-SHIFT aborts without a done pulse
      run(16'h0001, 1'b0, 16'h8000, 15, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle("abort");
      stray_done = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done) stray_done = 1'b1;
      end
      chk("abort_no_done", 32'(stray_done), 32'd0);

      // Fresh operation after abort, then result holds while idle
      run(16'h00F0, 1'b0, 16'hF000,  8, 1'b0, 1'b1); wait_done();
      repeat (3) @(negedge clk);
      chk("hold_out",   32'(out),   32'h0000F000);
      chk("hold_count", 32'(count), 32'd8);
      chk("hold_done",  32'(done),  32'd0);

      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
